// File: rtl/matrix_loader.sv
// Streams two matrices word by word into packed buses, then sequences the
// multiplier: reset pulse, start pulse, wait for finish (or timeout), show pulse.
module matrix_loader #(
  parameter int r1      = 2,
  parameter int c1      = 2,
  parameter int c2      = 2,
  parameter int width   = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [width-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      abort,
  output logic [r1*c1*width-1:0]    mat1,
  output logic [c1*c2*width-1:0]    mat2,
  output logic                      mult_rst,
  output logic                      start,
  input  logic                      finish,
  output logic                      show,
  output logic                      done,
  output logic                      timeout_err
);

  // state  | meaning
  // LOAD1  | accepting matrix 1 words, row-major
  // LOAD2  | accepting matrix 2 words, column-major
  // CLEAR  | one-cycle multiplier reset to drop a stale finish
  // LAUNCH | one-cycle start pulse
  // WAIT   | waiting for finish or timeout
  // SHOW   | one-cycle show/done pulse

  localparam int m1   = r1 * c1;
  localparam int m2   = c1 * c2;
  localparam int MMAX = (m1 > m2) ? m1 : m2;
  localparam int IW   = ($clog2(MMAX + 1) > 8) ? $clog2(MMAX + 1) : 8;
  localparam int TW   = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {LOAD1, LOAD2, CLEAR, LAUNCH, WAIT, SHOW} state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [TW-1:0] wcnt, wcnt_d;
  logic          tmo_d;
  logic          accept;

  // abort takes priority over a coinciding handshake
  assign accept = in_valid && in_ready && !abort;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    wcnt_d  = wcnt;
    tmo_d   = timeout_err;
    if (abort) begin
      state_d = LOAD1;
      idx_d   = '0;
    end else begin
      case (state)
        LOAD1: if (accept) begin
          if (idx == IW'(m1 - 1)) begin
            state_d = LOAD2;
            idx_d   = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
        LOAD2: if (accept) begin
          if (idx == IW'(m2 - 1)) begin
            state_d = CLEAR;
            idx_d   = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
        CLEAR:  state_d = LAUNCH;
        LAUNCH: begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
        WAIT: begin
          if (finish) begin
            state_d = SHOW;
          end else if (wcnt == TW'(TIMEOUT - 1)) begin
            state_d = SHOW;
            tmo_d   = 1'b1;
          end else begin
            wcnt_d = wcnt + TW'(1);
          end
        end
        SHOW:    state_d = LOAD1;
        default: state_d = LOAD1;
      endcase
    end
  end

  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOAD1;
      idx         <= '0;
      wcnt        <= '0;
      in_ready    <= 1'b0;
      mult_rst    <= 1'b0;
      start       <= 1'b0;
      show        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      wcnt        <= wcnt_d;
      timeout_err <= tmo_d;
      in_ready    <= (state_d == LOAD1) || (state_d == LOAD2);
      mult_rst    <= !(abort || (state_d == CLEAR));
      start       <= (state_d == LAUNCH);
      show        <= (state_d == SHOW);
      done        <= (state_d == SHOW);
    end
  end

  // first word of each matrix lands in the most significant slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      mat1 <= '0;
      mat2 <= '0;
    end else if (accept) begin
      if (state == LOAD1)
        mat1[(m1 - 1 - int'(idx)) * width +: width] <= in_data;
      else if (state == LOAD2)
        mat2[(m2 - 1 - int'(idx)) * width +: width] <= in_data;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized bench for matrix_loader: a word-level model predicts the packed
// matrices and timeout flag; a monitor checks them whenever done pulses.
module tb_matrix_loader;

  localparam int W  = 32;
  localparam int M  = 4;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic            abort;
  logic [M*W-1:0]  mat1;
  logic [M*W-1:0]  mat2;
  logic            mult_rst;
  logic            start;
  logic            finish;
  logic            show;
  logic            done;
  logic            timeout_err;

  matrix_loader #(.r1(2), .c1(2), .c2(2), .width(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .mat1(mat1), .mat2(mat2),
    .mult_rst(mult_rst), .start(start), .finish(finish), .show(show),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M*W-1:0] m1;
    logic [M*W-1:0] m2;
    logic           tmo;
  } exp_t;

  exp_t        exp_q[$];
  logic [W-1:0] m1v[M];
  logic [W-1:0] m2v[M];
  logic        tmo_sticky;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_start = 0;
  int          n_start_exp = 0;
  logic        prev_mrst = 1'b0;
  logic        prev_start = 1'b0;

  task automatic chk(input string nm, input logic [M*W-1:0] act, input logic [M*W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [M*W-1:0] pack1();
    logic [M*W-1:0] r = '0;
    for (int k = 0; k < M; k++) r = (r << W) | {{(M*W-W){1'b0}}, m1v[k]};
    return r;
  endfunction

  function automatic logic [M*W-1:0] pack2();
    logic [M*W-1:0] r = '0;
    for (int k = 0; k < M; k++) r = (r << W) | {{(M*W-W){1'b0}}, m2v[k]};
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < M; k++) begin
      m1v[k] = '0;
      m2v[k] = '0;
    end
    tmo_sticky = 1'b0;
  endtask

  // monitor: every done pulse must match the oldest predicted job
  always @(negedge clk) begin
    if (start) begin
      n_start++;
      chk("start_after_clear", prev_mrst, 0);
      chk("start_one_cycle", prev_start, 0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("job_mat1", mat1, e.m1);
        chk("job_mat2", mat2, e.m2);
        chk("job_timeout_err", timeout_err, e.tmo);
        chk("job_show", show, 1);
      end
    end
    prev_mrst  = mult_rst;
    prev_start = start;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mult_rst"}, mult_rst, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_show"}, show, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_mat1"}, mat1, 0);
    chk({tag, "_mat2"}, mat2, 0);
  endtask

  // called at a negedge; returns at a negedge after the word was taken
  task automatic send_word(input bit sel, input int k, input logic [W-1:0] w, input int gap);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_wait", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    if (sel) m2v[k] = w; else m1v[k] = w;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load_job(input logic [8*W-1:0] words, input bit rgap, input int first);
    for (int k = first; k < 2*M; k++) begin
      int g;
      g = (k == 2*M-1) ? 0 : (rgap ? int'($urandom_range(0, 2)) : 0);
      send_word(k >= M, k % M, words[8*W-1-W*k -: W], g);
    end
  endtask

  // mode 0: finish after d cycles, 1: timeout, 2: reset during WAIT
  task automatic finish_job(input int mode, input int d);
    int n;
    exp_t e;
    chk("clear_mult_rst", mult_rst, 0);
    chk("clear_start", start, 0);
    chk("clear_in_ready", in_ready, 0);
    @(negedge clk);
    chk("launch_start", start, 1);
    chk("launch_mult_rst", mult_rst, 1);
    n_start_exp++;
    if (mode == 0) begin
      e.m1 = pack1(); e.m2 = pack2(); e.tmo = tmo_sticky;
      exp_q.push_back(e);
      repeat (d) @(negedge clk);
      chk("wait_no_done", done, 0);
      finish = 1'b1;
      @(negedge clk);
      chk("finish_done", done, 1);
      chk("finish_show", show, 1);
      finish = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("back_to_load1", in_ready, 1);
    end else if (mode == 1) begin
      tmo_sticky = 1'b1;
      e.m1 = pack1(); e.m2 = pack2(); e.tmo = 1'b1;
      exp_q.push_back(e);
      n = 0;
      while (!done && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_latency", n, TO + 1);
      chk("timeout_err_set", timeout_err, 1);
      @(negedge clk);
      chk("timeout_done_one_cycle", done, 0);
      chk("timeout_back_to_load1", in_ready, 1);
      chk("timeout_err_sticky", timeout_err, 1);
    end else begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_reset_vals("rst_in_wait");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_release_in_ready", in_ready, 1);
      chk("rst_release_mult_rst", mult_rst, 1);
    end
  endtask

  function automatic logic [8*W-1:0] rand_words();
    logic [8*W-1:0] r = '0;
    for (int k = 0; k < 8; k++) r = (r << W) | {{(7*W){1'b0}}, W'($urandom)};
    return r;
  endfunction

  initial begin
    logic [8*W-1:0] wv;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; finish = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_mult_rst", mult_rst, 1);

    // directed 2x2 job, finish 5 cycles after start
    wv = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
          32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
    load_job(wv, 1'b0, 0);
    chk("dir_mat1", mat1, 128'h3F800000_40000000_40400000_40800000);
    chk("dir_mat2", mat2, 128'h3F800000_00000000_00000000_3F800000);
    finish_job(0, 5);

    // in_valid toggling 1,0,1,0 in LOAD1 takes exactly two words
    wv = rand_words();
    send_word(1'b0, 0, wv[8*W-1 -: W], 1);
    send_word(1'b0, 1, wv[7*W-1 -: W], 1);
    chk("toggle_in_ready", in_ready, 1);
    chk("toggle_mat1", mat1, pack1());
    load_job(wv, 1'b1, 2);
    finish_job(0, $urandom_range(1, 8));

    // timeout, then the flag stays set through a normal job
    load_job(rand_words(), 1'b1, 0);
    finish_job(1, 0);
    load_job(rand_words(), 1'b1, 0);
    finish_job(0, $urandom_range(1, 8));

    // abort with 3 of 4 mat2 words loaded, coinciding with a handshake
    wv = rand_words();
    for (int k = 0; k < 7; k++) send_word(k >= M, k % M, wv[8*W-1-W*k -: W], 0);
    in_valid = 1'b1; in_data = $urandom; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_mult_rst", mult_rst, 0);
    chk("abort_start", start, 0);
    chk("abort_done", done, 0);
    chk("abort_mat1", mat1, pack1());
    chk("abort_mat2", mat2, pack2());
    @(negedge clk);
    chk("abort_mult_rst_release", mult_rst, 1);
    load_job(rand_words(), 1'b1, 0);
    finish_job(0, $urandom_range(1, 8));

    // reset during WAIT discards the job
    load_job(rand_words(), 1'b1, 0);
    finish_job(2, 0);

    for (int j = 0; j < 5; j++) begin
      load_job(rand_words(), 1'b1, 0);
      finish_job(0, $urandom_range(1, 8));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("start_count", n_start, n_start_exp);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
